range_sched: RTL and testbench
==============================

// Module: range_sched
// PURPOSE
//  Round-robin scheduler sharing one range-finder datapath (go/finish/data_in -> range) among NREQ
//  sample-burst requesters. Grants one burst at a time, sequences rf_go/rf_finish/rf_data to the
//  datapath, captures rf_range, returns it with requester id over a valid/ready result port.
// PARAMETERS
//  WIDTH  16  sample and range width
//  NREQ   4   number of requesters (>=2)
//  IDW    2   width of res_id, $clog2(NREQ)
//  TMO    15  idle-beat timeout in cycles (used only with RANGE_SCHED_TIMEOUT_EN)
// PORTS
//  clock      in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high
//  req_valid  in   NREQ        per-requester beat valid
//  req_last   in   NREQ        per-requester last beat of burst
//  req_data   in   NREQ*WIDTH  per-requester sample, requester i at [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ        beat accepted when req_valid[i] & req_ready[i]
//  rf_go      out  1           start pulse to datapath
//  rf_finish  out  1           finish pulse to datapath
//  rf_data    out  WIDTH       sample to datapath
//  rf_range   in   WIDTH       datapath range, valid the 2nd cycle after rf_finish is seen high
//  rf_error   in   1           datapath error flag
//  res_valid  out  1           result valid
//  res_ready  in   1           result accepted when res_valid & res_ready
//  res_id     out  IDW         requester index of result
//  res_range  out  WIDTH       captured range
//  busy       out  1           high in every state except IDLE
//  err_sticky out  1           set on any rf_error cycle; cleared only by reset
// BEHAVIOUR
//  - All rf_*, res_*, busy, err_sticky registered. Reset: all outputs 0, state IDLE, rr pointer=NREQ-1.
//  - req_ready[i] = 1 only in ARM/STREAM and i == granted index; all other bits 0. Never reg'd late.
//  - FSM: IDLE -> ARM -> PRIME -> STREAM -> DRAIN -> CAPT -> RESULT -> IDLE.
//  - IDLE: if any req_valid, grant first set index after rr pointer (wrapping); latch grant; -> ARM.
//  - ARM: wait for granted beat; on accept: rf_go<=1, rf_data<=beat, store last flag; -> PRIME.
//  - PRIME (1 cycle, no accept): rf_go<=0. If stored last: rf_finish<=1, -> DRAIN; else -> STREAM.
//  - STREAM: on accept rf_data<=beat; on accept with req_last: rf_finish<=1, -> DRAIN.
//    Bubbles (no valid): rf_data holds last sample (repeat is min/max neutral); no timeout by default.
//  - DRAIN (1 cycle): rf_finish<=0. CAPT: res_range<=rf_range, res_id<=grant, res_valid<=1; -> RESULT.
//  - RESULT: hold res_* stable while res_valid & !res_ready; on handshake res_valid<=0,
//    rr pointer<=grant, -> IDLE. Next grant possible the cycle after (no bypass).
//  - rf_go and rf_finish each exactly 1 cycle wide, never high together; >=1 cycle apart.
//  - Datapath timing: go seen at c -> samples rf_data from c+1; finish seen at c -> range at c+2.
//  - Single-beat burst legal: finish issued from PRIME, range = 0 expected from datapath.
//  - Burst length unbounded; arithmetic none locally (range computed in datapath).
//  - Requester deasserting req_valid mid-burst keeps grant; others wait.
//  - Reset mid-burst: immediate return to IDLE, outputs 0; in-flight burst discarded.
// CONFIGURATION
//  RANGE_SCHED_TIMEOUT_EN defined: STREAM counts consecutive bubble cycles; at TMO forces
//   rf_finish<=1, -> DRAIN, result flagged via extra output res_tmo (1 bit, reg'd, reset 0);
//   granted requester's remaining beats: req_ready stays 0 until its next grant. Counter clears on accept.
//  Not defined: no counter, no res_tmo port; STREAM waits indefinitely.
// TESTING
//  1. Req0 burst 5,9,2,7(last) -> rf_go once, rf_finish once, res_id=0, res_range=7 (9-2).
//  2. Req1 & req3 valid in IDLE after reset -> req1 granted first, then req3; res_id 1 then 3.
//  3. Single beat 0x1234 (last) on req2 -> finish 1 cycle after go+1, res_range=0, res_id=2.
//  4. Bubbles: req0 10,_,_,40(last) -> rf_data holds 10 during bubbles, res_range=30.
//  5. res_ready low 3 cycles -> res_valid/res_range/res_id stable; no new grant till handshake.
//  6. reset asserted in STREAM -> all outputs 0 same cycle; next burst from req0 processed cleanly.

Source files
------------

// File: rtl/range_sched.sv
// range_sched: round-robin scheduler that shares one range-finder datapath
// among NREQ sample-burst requesters. One burst is granted at a time. The
// block sequences go/finish/data to the datapath, captures the range it
// returns, and presents that range with the requester id on a valid/ready
// result port.
// Optional feature: define RANGE_SCHED_TIMEOUT_EN to end a stalled burst
// after TMO consecutive bubble cycles. That build adds the TMO parameter and
// the res_tmo output.
module range_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
`ifdef RANGE_SCHED_TIMEOUT_EN
  , parameter int TMO = 15
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rf_go,
  output logic                  rf_finish,
  output logic [WIDTH-1:0]      rf_data,
  input  logic [WIDTH-1:0]      rf_range,
  input  logic                  rf_error,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_range,
  output logic                  busy,
  output logic                  err_sticky
`ifdef RANGE_SCHED_TIMEOUT_EN
  , output logic                res_tmo
`endif
);

  typedef enum logic [2:0] {
    IDLE, ARM, PRIME, STREAM, DRAIN, CAPT, RESULT
  } stateT;

  stateT            state_q;
  logic [IDW-1:0]   rrPtr_q;
  logic [IDW-1:0]   grant_q;
  logic             lastFlag_q;
  logic             rfGo_q;
  logic             rfFinish_q;
  logic [WIDTH-1:0] rfData_q;
  logic             resValid_q;
  logic [IDW-1:0]   resId_q;
  logic [WIDTH-1:0] resRange_q;
  logic             busy_q;
  logic             errSticky_q;

  logic [IDW-1:0]   grantIdx;
  logic [IDW-1:0]   scanIdx;
  logic             grantFound;
  logic [WIDTH-1:0] beatData;
  logic             beatValid;
  logic             beatLast;
  logic             accept;

`ifdef RANGE_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TMO + 1);
  logic [TCW-1:0] bubbleCnt_q;
  logic           tmoHit_q;
  logic           resTmo_q;
  assign res_tmo = resTmo_q;
`endif

  // Round-robin search: first requester with a valid beat after the pointer, wrapping.
  always_comb begin
    grantIdx   = '0;
    scanIdx    = '0;
    grantFound = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      scanIdx = IDW'((int'(rrPtr_q) + k) % NREQ);
      if (!grantFound && req_valid[scanIdx]) begin
        grantFound = 1'b1;
        grantIdx   = scanIdx;
      end
    end
  end

  // Select the granted requester's sample lane.
  always_comb begin
    beatData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) beatData = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign beatValid = req_valid[grant_q];
  assign beatLast  = req_last[grant_q];
  assign accept    = beatValid && (state_q == ARM || state_q == STREAM);

  // Ready comes straight from the registered state, so the granted requester sees it in the same cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == ARM || state_q == STREAM) req_ready[grant_q] = 1'b1;
  end

  // Scheduler FSM with all datapath and result outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= IDW'(NREQ - 1);
      grant_q     <= '0;
      lastFlag_q  <= 1'b0;
      rfGo_q      <= 1'b0;
      rfFinish_q  <= 1'b0;
      rfData_q    <= '0;
      resValid_q  <= 1'b0;
      resId_q     <= '0;
      resRange_q  <= '0;
      busy_q      <= 1'b0;
      errSticky_q <= 1'b0;
`ifdef RANGE_SCHED_TIMEOUT_EN
      bubbleCnt_q <= '0;
      tmoHit_q    <= 1'b0;
      resTmo_q    <= 1'b0;
`endif
    end else begin
      errSticky_q <= errSticky_q | rf_error;
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            grant_q <= grantIdx;
            busy_q  <= 1'b1;
            state_q <= ARM;
`ifdef RANGE_SCHED_TIMEOUT_EN
            bubbleCnt_q <= '0;
            tmoHit_q    <= 1'b0;
`endif
          end
        end
        ARM: begin
          if (accept) begin
            rfGo_q     <= 1'b1;
            rfData_q   <= beatData;
            lastFlag_q <= beatLast;
            state_q    <= PRIME;
          end
        end
        PRIME: begin
          rfGo_q <= 1'b0;
          if (lastFlag_q) begin
            rfFinish_q <= 1'b1;
            state_q    <= DRAIN;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            rfData_q <= beatData;
`ifdef RANGE_SCHED_TIMEOUT_EN
            bubbleCnt_q <= '0;
`endif
            if (beatLast) begin
              rfFinish_q <= 1'b1;
              state_q    <= DRAIN;
            end
          end
`ifdef RANGE_SCHED_TIMEOUT_EN
          else if (bubbleCnt_q == TCW'(TMO - 1)) begin
            rfFinish_q  <= 1'b1;
            tmoHit_q    <= 1'b1;
            bubbleCnt_q <= '0;
            state_q     <= DRAIN;
          end else begin
            bubbleCnt_q <= bubbleCnt_q + 1'b1;
          end
`endif
        end
        DRAIN: begin
          rfFinish_q <= 1'b0;
          state_q    <= CAPT;
        end
        CAPT: begin
          resRange_q <= rf_range;
          resId_q    <= grant_q;
          resValid_q <= 1'b1;
`ifdef RANGE_SCHED_TIMEOUT_EN
          resTmo_q   <= tmoHit_q;
`endif
          state_q    <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            rrPtr_q    <= grant_q;
            busy_q     <= 1'b0;
`ifdef RANGE_SCHED_TIMEOUT_EN
            resTmo_q   <= 1'b0;
`endif
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_go      = rfGo_q;
  assign rf_finish  = rfFinish_q;
  assign rf_data    = rfData_q;
  assign res_valid  = resValid_q;
  assign res_id     = resId_q;
  assign res_range  = resRange_q;
  assign busy       = busy_q;
  assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_range_sched.sv
// Testbench for range_sched. A behavioural range-finder answers the
// go/finish/data handshake. Expected results come from the burst contents
// (max - min) and from the round-robin order of the pending requesters.
module tb_range_sched;

  localparam int WIDTH  = 16;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int MAXLEN = 8;
  localparam int BUDGET = 3000;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ-1:0]       reqLast;
  logic [NREQ*WIDTH-1:0] reqData;
  logic [NREQ-1:0]       reqReady;
  logic                  rfGo;
  logic                  rfFinish;
  logic [WIDTH-1:0]      rfData;
  logic [WIDTH-1:0]      rfRange;
  logic                  rfError;
  logic                  resValid;
  logic                  resReady;
  logic [IDW-1:0]        resId;
  logic [WIDTH-1:0]      resRange;
  logic                  busy;
  logic                  errSticky;
`ifdef RANGE_SCHED_TIMEOUT_EN
  logic                  resTmo;
`endif

  logic [WIDTH-1:0] burstBeat [NREQ][MAXLEN];
  int               burstLen  [NREQ];
  int               burstGap  [NREQ][MAXLEN];
  int               expId [$];
  logic [WIDTH-1:0] expRange [$];
  int               lastServed;
  int               checkCount = 0;
  int               errorCount = 0;

  range_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_last   (reqLast),
    .req_data   (reqData),
    .req_ready  (reqReady),
    .rf_go      (rfGo),
    .rf_finish  (rfFinish),
    .rf_data    (rfData),
    .rf_range   (rfRange),
    .rf_error   (rfError),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_id     (resId),
    .res_range  (resRange),
    .busy       (busy),
    .err_sticky (errSticky)
`ifdef RANGE_SCHED_TIMEOUT_EN
    , .res_tmo  (resTmo)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural range finder: tracks min/max of rf_data from go through finish and holds the range.
  initial begin : datapathModel
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             active;
    active  = 1'b0;
    lo      = '0;
    hi      = '0;
    rfRange = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        active = 1'b0;
      end else begin
        if (rfGo) begin
          active = 1'b1;
          lo = rfData;
          hi = rfData;
        end else if (active) begin
          if (rfData < lo) lo = rfData;
          if (rfData > hi) hi = rfData;
        end
        if (rfFinish && active) begin
          rfRange = hi - lo;
          active  = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] rangeOf(input int r);
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    lo = burstBeat[r][0];
    hi = burstBeat[r][0];
    for (int j = 1; j < burstLen[r]; j++) begin
      if (burstBeat[r][j] < lo) lo = burstBeat[r][j];
      if (burstBeat[r][j] > hi) hi = burstBeat[r][j];
    end
    return hi - lo;
  endfunction

  task automatic clearBursts();
    for (int r = 0; r < NREQ; r++) begin
      burstLen[r] = 1;
      for (int j = 0; j < MAXLEN; j++) begin
        burstBeat[r][j] = '0;
        burstGap[r][j]  = 0;
      end
    end
  endtask

  // Runs one round: every requester in mask offers its burst; entered and left at posedge+1.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int readyMode, input int abortAfter);
    int pos [NREQ];
    int gapLeft [NREQ];
    int cyc, holdCnt, goCnt, finCnt, nBursts, acceptTotal, goCyc, curLen;
    logic prevGo, prevFin, prevHold, inBurst, aborted;
    logic [WIDTH-1:0] lastBeat;
    logic [NREQ-1:0] acc;
    cyc = 0; holdCnt = 0; goCnt = 0; finCnt = 0; nBursts = 0;
    acceptTotal = 0; goCyc = -10; curLen = 0;
    prevGo = 1'b0; prevFin = 1'b0; prevHold = 1'b0; inBurst = 1'b0; aborted = 1'b0;
    lastBeat = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int r;
      r = (lastServed + k) % NREQ;
      if (mask[r]) begin
        expId.push_back(r);
        expRange.push_back(rangeOf(r));
        nBursts++;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0;
      gapLeft[i] = 0;
    end
    forever begin
      for (int i = 0; i < NREQ; i++) begin
        reqValid[i] = mask[i] && (pos[i] < burstLen[i]) && (gapLeft[i] == 0);
        reqLast[i]  = mask[i] && (pos[i] == burstLen[i] - 1);
        reqData[i*WIDTH +: WIDTH] = (pos[i] < burstLen[i]) ? burstBeat[i][pos[i]] : '0;
      end
      if (readyMode == 0) resReady = 1'b1;
      else if (readyMode == 1) resReady = (holdCnt >= 3);
      else resReady = ($urandom_range(0, 3) != 0);
      if (expId.size() == 0 || cyc >= BUDGET || aborted) break;

      @(negedge clock);
      checkOutput("goFinishExcl", 32'(rfGo & rfFinish), 32'd0);
      checkOutput("goWidth", 32'(rfGo & prevGo), 32'd0);
      checkOutput("finishWidth", 32'(rfFinish & prevFin), 32'd0);
      if (rfGo) begin
        goCnt++;
        goCyc = cyc;
      end
      if (rfFinish) begin
        finCnt++;
        if (curLen == 1) checkOutput("singleBeatGap", cyc - goCyc, 32'd1);
      end
      prevGo  = rfGo;
      prevFin = rfFinish;
      if (inBurst && reqReady != '0) checkOutput("rfDataHold", 32'(rfData), 32'(lastBeat));
      if (prevHold) checkOutput("resHoldValid", 32'(resValid), 32'd1);
      if (resValid && !resReady && expId.size() > 0) begin
        checkOutput("resHoldId", 32'(resId), expId[0]);
        checkOutput("resHoldRange", 32'(resRange), 32'(expRange[0]));
        checkOutput("noGrantInHold", 32'(reqReady), 32'd0);
        checkOutput("busyInHold", 32'(busy), 32'd1);
      end
      acc = reqValid & reqReady;
      checkOutput("acceptOneHot", 32'($countones(acc) <= 1), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          if (pos[i] == 0) begin
            inBurst = 1'b1;
            curLen  = burstLen[i];
          end
          lastBeat = burstBeat[i][pos[i]];
          if (pos[i] == burstLen[i] - 1) inBurst = 1'b0;
          acceptTotal++;
        end
      end
      if (resValid && resReady && expId.size() > 0) begin
        checkOutput("resId", 32'(resId), expId[0]);
        checkOutput("resRange", 32'(resRange), 32'(expRange[0]));
        lastServed = expId.pop_front();
        void'(expRange.pop_front());
        holdCnt = 0;
      end
      prevHold = resValid && !resReady;
      if (prevHold) holdCnt++;

      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          pos[i]++;
          gapLeft[i] = (pos[i] < burstLen[i]) ? burstGap[i][pos[i]] : 0;
        end else if (gapLeft[i] > 0) begin
          gapLeft[i]--;
        end
      end
      cyc++;
      if (abortAfter > 0 && acceptTotal >= abortAfter) aborted = 1'b1;
    end
    if (!aborted) begin
      checkOutput("goCount", goCnt, nBursts);
      checkOutput("finishCount", finCnt, nBursts);
      checkOutput("pendingResults", expId.size(), 32'd0);
      expId.delete();
      expRange.delete();
      @(negedge clock);
      checkOutput("idleBusy", 32'(busy), 32'd0);
      checkOutput("idleResValid", 32'(resValid), 32'd0);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_go"}, 32'(rfGo), 32'd0);
    checkOutput({tag, "_finish"}, 32'(rfFinish), 32'd0);
    checkOutput({tag, "_data"}, 32'(rfData), 32'd0);
    checkOutput({tag, "_resValid"}, 32'(resValid), 32'd0);
    checkOutput({tag, "_resId"}, 32'(resId), 32'd0);
    checkOutput({tag, "_resRange"}, 32'(resRange), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_errSticky"}, 32'(errSticky), 32'd0);
    checkOutput({tag, "_reqReady"}, 32'(reqReady), 32'd0);
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; reqLast = '0; reqData = '0;
    rfError = 1'b0; resReady = 1'b0; lastServed = NREQ - 1;
    clearBursts();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] two requesters after reset, round-robin order");
    clearBursts();
    burstLen[1] = 2; burstBeat[1][0] = 16'd3; burstBeat[1][1] = 16'd8;
    burstLen[3] = 3; burstBeat[3][0] = 16'd100; burstBeat[3][1] = 16'd50; burstBeat[3][2] = 16'd75;
    applyStimulus(4'b1010, 0, 0);

    $display("[TB] req0 burst 5,9,2,7");
    clearBursts();
    burstLen[0] = 4;
    burstBeat[0][0] = 16'd5; burstBeat[0][1] = 16'd9; burstBeat[0][2] = 16'd2; burstBeat[0][3] = 16'd7;
    applyStimulus(4'b0001, 0, 0);

    $display("[TB] error flag is sticky");
    @(negedge clock);
    checkOutput("errBefore", 32'(errSticky), 32'd0);
    @(posedge clock);
    #1;
    rfError = 1'b1;
    @(posedge clock);
    #1;
    rfError = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("errAfter", 32'(errSticky), 32'd1);
    @(posedge clock);
    #1;

    $display("[TB] single-beat burst on req2");
    clearBursts();
    burstLen[2] = 1; burstBeat[2][0] = 16'h1234;
    applyStimulus(4'b0100, 0, 0);

    $display("[TB] bubbles inside a burst");
    clearBursts();
    burstLen[0] = 2; burstBeat[0][0] = 16'd10; burstBeat[0][1] = 16'd40; burstGap[0][1] = 3;
    applyStimulus(4'b0001, 0, 0);

    $display("[TB] result backpressure with a second requester waiting");
    clearBursts();
    burstLen[2] = 2; burstBeat[2][0] = 16'h0100; burstBeat[2][1] = 16'h0050;
    burstLen[1] = 1; burstBeat[1][0] = 16'h0077;
    applyStimulus(4'b0110, 1, 0);

    $display("[TB] randomized rounds");
    for (int n = 0; n < 24; n++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        burstLen[r] = int'($urandom_range(1, MAXLEN));
        for (int j = 0; j < MAXLEN; j++) begin
          burstBeat[r][j] = WIDTH'($urandom());
          burstGap[r][j]  = (j > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
      end
      applyStimulus(mask, 2, 0);
    end

    $display("[TB] reset during streaming");
    @(negedge clock);
    checkOutput("errStillSet", 32'(errSticky), 32'd1);
    @(posedge clock);
    #1;
    clearBursts();
    burstLen[0] = 6;
    for (int j = 0; j < 6; j++) burstBeat[0][j] = WIDTH'(16'h11 * (j + 1));
    applyStimulus(4'b0001, 0, 2);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midReset");
    expId.delete();
    expRange.delete();
    lastServed = NREQ - 1;
    reqValid = '0;
    reqLast  = '0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    clearBursts();
    burstLen[0] = 3;
    burstBeat[0][0] = 16'd300; burstBeat[0][1] = 16'd20; burstBeat[0][2] = 16'd1000;
    applyStimulus(4'b0001, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
